mux4_arbiter: RTL and testbench

MUX4_ARBITER -- requirements
Module: mux4_arbiter

---
 rtl/mux4_arbiter.sv | 129 ++++++++++++
 tb/tb_mux4_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin arbiter for four requesters driving one shared
// DW-bit output through a valid/ready handshake, with a transfer counter.
module mux4_arbiter #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  input  logic          out_ready,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic [15:0]   xfer_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nx;
  logic [1:0]  sel_q, sel_nx;
  logic [1:0]  ptr_q, ptr_nx;
  logic [15:0] cnt_q, cnt_nx;
  logic [3:0]  sel_oh;
  logic [3:0]  arb_req;
  logic [1:0]  arb_start;
  logic [1:0]  arb_win;
  logic [1:0]  arb_idx;
  logic        arb_hit;
  logic        xfer;

  // One-hot form of the current selection
  always_comb sel_oh = 4'b0001 << sel_q;

  // Arbitration source: fresh requests in IDLE, or the current holder masked
  // out and the search rotated past it when re-arbitrating on a transfer
  always_comb begin
    arb_req   = req;
    arb_start = ptr_q;
    if (state == BUSY) begin
      arb_req   = req & ~sel_oh;
      arb_start = sel_q + 2'd1;
    end
  end

  // Round-robin search: first set request starting at arb_start, wrapping mod 4
  always_comb begin
    arb_win = arb_start;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      arb_idx = arb_start + 2'(i);
      if (!arb_hit && arb_req[arb_idx]) begin
        arb_hit = 1'b1;
        arb_win = arb_idx;
      end
    end
  end

  // Next-state logic: arbitrate, stall, transfer (with back-to-back regrant) or abort
  always_comb begin
    state_nx = state;
    sel_nx   = sel_q;
    ptr_nx   = ptr_q;
    cnt_nx   = cnt_q;
    xfer     = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_hit) begin
          sel_nx   = arb_win;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (!req[sel_q]) begin
          state_nx = IDLE;
          ptr_nx   = sel_q + 2'd1;
        end else if (out_ready) begin
          xfer   = 1'b1;
          cnt_nx = cnt_q + 16'd1;
          ptr_nx = sel_q + 2'd1;
          if (arb_hit) begin
            sel_nx = arb_win;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset overrides any transfer in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      sel_q <= sel_nx;
      ptr_q <= ptr_nx;
      cnt_q <= cnt_nx;
    end
  end

  // Outputs: grant derived from registered state so it is always one-hot(sel) or zero
  always_comb begin
    out_valid = (state == BUSY);
    gnt       = out_valid ? sel_oh : '0;
    sel       = sel_q;
    xfer_cnt  = cnt_q;
    out       = '0;
    if (out_valid) begin
      unique case (sel_q)
        2'd0: out = in0;
        2'd1: out = in1;
        2'd2: out = in2;
        2'd3: out = in3;
        default: out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: vector table, directed corner sequences, and random traffic
// checked against a behavioural model of the arbitration rules.
module tb_mux4_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  din [4];
  logic        out_ready;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [7:0]  out;
  logic        out_valid;
  logic [15:0] xfer_cnt;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int m_busy = 0;
  int m_sel  = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  mux4_arbiter #(.DW(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .out_ready(out_ready), .gnt(gnt), .sel(sel), .out(out),
    .out_valid(out_valid), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        v;
    logic [7:0]  out;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // first requester found scanning r from index start upward, modulo 4
  function automatic int first_from(input int r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_step();
    int m;
    if (rst) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_busy == 0) begin
      if (req != 0) begin
        m_sel  = first_from(int'(req), m_ptr);
        m_busy = 1;
      end
    end else if (req[m_sel] == 1'b0) begin
      m_busy = 0;
      m_ptr  = (m_sel + 1) % 4;
    end else if (out_ready) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_ptr = (m_sel + 1) % 4;
      m = int'(req) & ~(1 << m_sel);
      if (m != 0) m_sel = first_from(m, m_ptr);
      else m_busy = 0;
    end
  endtask

  // advance one clock: model follows the inputs present before the edge
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".gnt"}, 32'(gnt), (m_busy != 0) ? (32'd1 << m_sel) : 32'd0);
    chk({nm, ".valid"}, 32'(out_valid), 32'(m_busy));
    chk({nm, ".sel"}, 32'(sel), 32'(m_sel));
    chk({nm, ".out"}, 32'(out), (m_busy != 0) ? 32'(din[m_sel]) : 32'd0);
    chk({nm, ".cnt"}, 32'(xfer_cnt), 32'(m_cnt));
  endtask

  task automatic chk_hard(input string nm, input logic [3:0] g, input logic [1:0] s,
                          input logic v, input logic [15:0] c);
    chk({nm, ".gnt"}, 32'(gnt), 32'(g));
    chk({nm, ".sel"}, 32'(sel), 32'(s));
    chk({nm, ".valid"}, 32'(out_valid), 32'(v));
    chk({nm, ".cnt"}, 32'(xfer_cnt), 32'(c));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; out_ready = 1'b0;
    din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'hA5; din[3] = 8'h44;

    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00, 16'd0};
    tbl[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5, 16'd0};
    tbl[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 8'h00, 16'd1};
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 8'h00, 16'd1};
    tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00, 16'd0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11, 16'd0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h22, 16'd1};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5, 16'd2};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 8'h44, 16'd3};
    tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11, 16'd4};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00, 16'd4};

    // vector table: single request, then round-robin with all requesting
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; out_ready = tbl[i].rdy;
      cycle();
      chk_hard($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].v, tbl[i].cnt);
      chk($sformatf("tbl%0d.out", i), 32'(out), 32'(tbl[i].out));
    end

    // stall on requester 1: grant and count hold, out follows in1
    do_reset();
    req = 4'b0010; out_ready = 1'b0;
    cycle();
    chk_hard("stall.grant", 4'b0010, 2'd1, 1'b1, 16'd0);
    for (int i = 0; i < 5; i++) begin
      din[1] = 8'(8'h30 + i);
      #1;
      chk($sformatf("stall%0d.out", i), 32'(out), 32'(8'h30 + i));
      cycle();
      chk_hard($sformatf("stall%0d", i), 4'b0010, 2'd1, 1'b1, 16'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk_hard("stall.xfer", 4'b0000, 2'd1, 1'b0, 16'd1);
    req = 4'b0000;
    cycle();

    // pointer wrap after serving requester 3
    do_reset();
    req = 4'b1000; out_ready = 1'b1;
    cycle();
    chk_hard("wrap.grant3", 4'b1000, 2'd3, 1'b1, 16'd0);
    cycle();
    chk_hard("wrap.idle", 4'b0000, 2'd3, 1'b0, 16'd1);
    req = 4'b1001;
    cycle();
    chk_hard("wrap.grant0", 4'b0001, 2'd0, 1'b1, 16'd1);
    req = 4'b0000;
    cycle();

    // abort on requester 2, then pointer continues from 3
    do_reset();
    req = 4'b0100; out_ready = 1'b0;
    cycle();
    chk_hard("abort.grant", 4'b0100, 2'd2, 1'b1, 16'd0);
    req = 4'b0000;
    cycle();
    chk_hard("abort.idle", 4'b0000, 2'd2, 1'b0, 16'd0);
    req = 4'b0101;
    cycle();
    chk_hard("abort.regrant", 4'b0001, 2'd0, 1'b1, 16'd0);
    req = 4'b0000;
    cycle();

    // reset coinciding with a transfer
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk_hard("rstx.pre", 4'b0010, 2'd1, 1'b1, 16'd5);
    rst = 1'b1;
    cycle();
    chk_hard("rstx.post", 4'b0000, 2'd0, 1'b0, 16'd0);
    rst = 1'b0; req = 4'b0000;
    cycle();

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      req = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) din[k] = 8'($urandom);
      #1;
      chk_model($sformatf("rnd%0d.pre", i));
      cycle();
      chk_model($sformatf("rnd%0d", i));
    end

    // counter wrap: 0xFFFF transfers, then one more
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    cycle();
    for (int i = 0; i < 65535; i++) cycle();
    chk("cntwrap.ffff", 32'(xfer_cnt), 32'h0000FFFF);
    chk_model("cntwrap.ffff.model");
    cycle();
    chk("cntwrap.zero", 32'(xfer_cnt), 32'h00000000);
    chk_model("cntwrap.zero.model");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
